// File: rtl/delay_line.sv
// Programmable integer-sample delay: outputs the PCM sample presented
// `delay` clocks earlier (0-31), through a registered output stage.
module delay_line #(
  parameter int unsigned DATA_W = 19,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        delay,
  input  logic [DATA_W-1:0] pcm_data,
  output logic [DATA_W-1:0] delayed_pcm_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // hist[0] is the newest stored sample, hist[DEPTH-1] the oldest.
  logic [DATA_W-1:0] hist [DEPTH];
  logic [DATA_W-1:0] tap;
  logic [IDX_W-1:0]  tap_idx;

  // Tap select from the pre-edge history; delay 0 bypasses the history.
  always_comb begin
    tap_idx = IDX_W'(delay - 5'd1);
    tap     = pcm_data;
    if (delay != 5'd0) begin
      tap = hist[tap_idx];
    end
  end

  // History shift register and registered output, both cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) begin
        hist[k] <= '0;
      end
      delayed_pcm_data <= '0;
    end else begin
      hist[0] <= pcm_data;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        hist[k] <= hist[k-1];
      end
      delayed_pcm_data <= tap;
    end
  end

endmodule

// File: tb/tb_delay_line.sv
// Directed self-checking bench for delay_line; a second instance with a
// fixed delay of 12 shares the stream for the relative-offset check.
module tb_delay_line;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  delay;
  logic [4:0]  delay2;
  logic [18:0] pcm_data;
  logic [18:0] out1;
  logic [18:0] out2;

  int checks = 0;
  int errors = 0;

  delay_line #(.DATA_W(19), .DEPTH(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .delay            (delay),
    .pcm_data         (pcm_data),
    .delayed_pcm_data (out1)
  );

  delay_line #(.DATA_W(19), .DEPTH(32)) dut2 (
    .clk              (clk),
    .rst              (rst),
    .delay            (delay2),
    .pcm_data         (pcm_data),
    .delayed_pcm_data (out2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one sample, clock it in, and settle just after the edge.
  task automatic step(input logic [18:0] d);
    pcm_data = d;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(19'h12345);
    rst = 1'b0;
  endtask

  initial begin
    logic [18:0] pat [3];
    logic [18:0] exp;
    int          d;

    pat[0] = 19'h7FFFF;
    pat[1] = 19'h40000;
    pat[2] = 19'h00001;

    rst      = 1'b1;
    delay    = 5'd0;
    delay2   = 5'd12;
    pcm_data = 19'h0;

    // Reset state: both outputs cleared, input ignored during reset.
    step(19'h55555);
    step(19'h2AAAA);
    check("reset_out1", out1, 19'h0);
    check("reset_out2", out2, 19'h0);
    rst = 1'b0;

    // Delay 0: output follows the input after the same edge.
    for (int i = 1; i <= 8; i++) begin
      step(19'(i));
      check("d0_ramp", out1, 19'(i));
    end

    // Delay 14 after a fresh reset.
    do_reset();
    delay = 5'd14;
    for (int i = 0; i < 40; i++) begin
      step(19'(100 + i));
      exp = (i < 14) ? 19'h0 : 19'(100 + i - 14);
      check("d14_ramp", out1, exp);
    end

    // Delay 31: deepest tap.
    do_reset();
    delay = 5'd31;
    for (int i = 0; i < 46; i++) begin
      step(19'(200 + i));
      exp = (i < 31) ? 19'h0 : 19'(200 + i - 31);
      check("d31_ramp", out1, exp);
    end

    // Delay changes mid-stream: 4 -> 10 -> 2.
    do_reset();
    for (int i = 0; i < 60; i++) begin
      d = (i < 20) ? 4 : (i < 40) ? 10 : 2;
      delay = 5'(d);
      step(19'(1000 + i));
      exp = (i < d) ? 19'h0 : 19'(1000 + i - d);
      check("switch_ramp", out1, exp);
    end

    // Full-width bit patterns through delay 7.
    do_reset();
    delay = 5'd7;
    for (int i = 0; i < 30; i++) begin
      step(pat[i % 3]);
      exp = (i < 7) ? 19'h0 : pat[(i - 7) % 3];
      check("d7_pattern", out1, exp);
    end

    // Mid-stream reset pulse with delay 5: old history must not reappear.
    do_reset();
    delay = 5'd5;
    for (int i = 0; i < 20; i++) begin
      step(19'(3000 + i));
    end
    check("pre_pulse", out1, 19'(3000 + 19 - 5));
    rst = 1'b1;
    step(19'd9999);
    check("pulse_edge", out1, 19'h0);
    rst = 1'b0;
    for (int j = 0; j < 15; j++) begin
      step(19'(4000 + j));
      exp = (j < 5) ? 19'h0 : 19'(4000 + j - 5);
      check("post_pulse", out1, exp);
    end

    // Two instances, delays 0 and 12, same stream.
    do_reset();
    delay = 5'd0;
    for (int i = 0; i < 30; i++) begin
      step(19'(5000 + i));
      check("pair_d0", out1, 19'(5000 + i));
      exp = (i < 12) ? 19'h0 : 19'(5000 + i - 12);
      check("pair_d12", out2, exp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
